// File: rtl/div_issue_ctrl.sv
// Requester-side issue controller for the iterative divider: buffers DIV/REM
// micro-ops in order, starts the divider one op at a time and writes results back.

`ifndef DIV_OP_DIV
`define DIV_OP_DIV  3'b001
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b010
`endif

module div_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [2:0]       div_opcode,
  output logic [31:0]      div_divident,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_finish,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data
);

  // state  | meaning
  // IDLE   | no op in the divider; issues the FIFO head when present
  // WAIT   | op in the divider, result still wanted
  // DRAIN  | op in the divider was flushed; wait for finish, then drop it
  // WB     | result held on the writeback port until accepted or flushed
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_WB} state_e;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  state_e state_q, state_d;

  logic [1:0]       f3_mem_q  [DEPTH];
  logic [31:0]      rs1_mem_q [DEPTH];
  logic [31:0]      rs2_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full, empty, push, pop, clr;

  logic [1:0]       head_f3;
  logic [TAG_W-1:0] head_tag;

  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rem_sel_q, rem_sel_d;
  logic [31:0]      data_q, data_d;

  logic unused_f3;
  assign unused_f3 = in_funct3[2];

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  assign head_f3  = f3_mem_q[rd_ptr_q];
  assign head_tag = tag_mem_q[rd_ptr_q];

  // Operands are presented from the head continuously; the divider only samples on div_start.
  assign div_opcode   = empty ? 3'b000 : (head_f3[0] ? `DIV_OP_DIVU : `DIV_OP_DIV);
  assign div_divident = empty ? 32'h0 : rs1_mem_q[rd_ptr_q];
  assign div_divisor  = empty ? 32'h0 : rs2_mem_q[rd_ptr_q];

  assign wb_tag  = tag_q;
  assign wb_data = data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      f3_mem_q[wr_ptr_q]  <= in_funct3[1:0];
      rs1_mem_q[wr_ptr_q] <= in_rs1;
      rs2_mem_q[wr_ptr_q] <= in_rs2;
      tag_mem_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      rem_sel_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      rem_sel_q <= rem_sel_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    rem_sel_d = rem_sel_q;
    data_d    = data_q;
    div_start = 1'b0;
    wb_valid  = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          clr = 1'b1;
        end else if (!empty) begin
          div_start = 1'b1;
          pop       = 1'b1;
          tag_d     = head_tag;
          rem_sel_d = head_f3[1];
          // Divide-by-zero and overflow finish in the start cycle.
          if (div_finish) begin
            data_d  = head_f3[1] ? div_remainder : div_quotient;
            state_d = S_WB;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = div_finish ? S_IDLE : S_DRAIN;
        end else if (div_finish) begin
          data_d  = rem_sel_q ? div_remainder : div_quotient;
          state_d = S_WB;
        end
      end
      S_DRAIN: begin
        if (div_finish) state_d = S_IDLE;
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (flush) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end else if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a small multi-cycle divider model
// that finishes in the start cycle on divide-by-zero and signed overflow.

`ifndef DIV_OP_DIV
`define DIV_OP_DIV  3'b001
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b010
`endif

module tb_div_issue_ctrl;
  localparam int TAG_W = 6;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_funct3 = '0;
  logic [31:0]      in_rs1 = '0;
  logic [31:0]      in_rs2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_start;
  logic [2:0]       div_opcode;
  logic [31:0]      div_divident, div_divisor;
  logic [31:0]      div_quotient, div_remainder;
  logic             div_finish;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .div_start(div_start), .div_opcode(div_opcode),
    .div_divident(div_divident), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_finish(div_finish),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  int checks = 0;
  int errors = 0;

  // RISC-V divide semantics for the divider model.
  function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op == `DIV_OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'h0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  logic        busy;
  logic [1:0]  cnt;
  logic [31:0] lq, lr, cq, cr;
  logic        imm;

  always_comb begin
    {cq, cr} = ref_div(div_opcode, div_divident, div_divisor);
    imm = (div_divisor == 32'h0) ||
          (div_opcode == `DIV_OP_DIV && div_divident == 32'h8000_0000 && div_divisor == 32'hFFFF_FFFF);
    div_finish    = (div_start && imm) || (busy && cnt == 2'd0);
    div_quotient  = busy ? lq : cq;
    div_remainder = busy ? lr : cr;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= 2'd0;
      lq   <= 32'h0;
      lr   <= 32'h0;
    end else if (div_start && !imm) begin
      busy <= 1'b1;
      cnt  <= 2'(LAT - 1);
      lq   <= cq;
      lr   <= cr;
    end else if (busy) begin
      if (cnt == 2'd0) busy <= 1'b0;
      else             cnt  <= cnt - 2'd1;
    end
  end

  int               n_start = 0;
  int               n_wbv = 0;
  int               n_viol = 0;
  logic             pending = 1'b0;
  logic [TAG_W+31:0] wb_log[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (div_start) begin
        n_start = n_start + 1;
        if (pending) n_viol = n_viol + 1;
        pending = 1'b1;
      end
      if (wb_valid) n_wbv = n_wbv + 1;
      if (wb_valid && wb_ready && !flush) begin
        wb_log.push_back({wb_tag, wb_data});
        pending = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_tag = t;
  endtask

  task automatic wait_wb(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (wb_valid) break;
      @(negedge clk); #1;
    end
    chk("wb_valid_timeout", wb_valid, 1);
  endtask

  // Enqueue one op into an idle, empty controller and follow it to writeback (wb_ready=1).
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic [31:0] exp, input logic [2:0] exp_op, input logic direct);
    int s;
    s = n_start;
    @(negedge clk); #1;
    chk({name, "_in_ready"}, in_ready, 1);
    drive_op(f3, a, b, t);
    @(negedge clk); in_valid = 1'b0; #1;
    chk({name, "_start"}, div_start, 1);
    chk({name, "_opcode"}, div_opcode, exp_op);
    @(negedge clk); #1;
    chk({name, "_direct_wb"}, wb_valid, direct);
    wait_wb(20);
    chk({name, "_wb_tag"}, wb_tag, t);
    chk({name, "_wb_data"}, wb_data, exp);
    @(negedge clk); #1;
    chk({name, "_wb_done"}, wb_valid, 0);
    chk({name, "_one_start"}, n_start - s, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s, sz;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_div_start", div_start, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_opcode", div_opcode, 0);
    chk("rst_divident", div_divident, 0);
    chk("rst_divisor", div_divisor, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1-2: basic divide and remainders
    wb_ready = 1'b1;
    run_op("div", 3'b100, 32'd100, 32'd7, 6'd3, 32'd14, `DIV_OP_DIV, 1'b0);
    run_op("rem_neg", 3'b110, 32'hFFFF_FF9C, 32'd7, 6'd4, 32'hFFFF_FFFE, `DIV_OP_DIV, 1'b0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 6'd5, 32'd2, `DIV_OP_DIVU, 1'b0);

    // 3: same-cycle finish goes straight to WB
    run_op("divu_by0", 3'b101, 32'h55, 32'h0, 6'd6, 32'hFFFF_FFFF, `DIV_OP_DIVU, 1'b1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7, 32'h0, `DIV_OP_DIV, 1'b1);

    // 4: five back-to-back ops with writeback stalled
    wb_ready = 1'b0;
    n_viol = 0; pending = 1'b0;
    s = n_start;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("fill_in_ready", in_ready, 1);
      drive_op(3'b101, 32'(20 * k + 5), 32'd5, 6'(10 + k));
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk("fill_full", in_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("stall_wb_valid", wb_valid, 1);
    chk("stall_wb_tag", wb_tag, 10);
    chk("stall_wb_data", wb_data, 1);
    chk("stall_one_start", n_start - s, 1);
    wb_log.delete();
    wb_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (wb_log.size() >= 5) break;
      @(negedge clk);
    end
    #1;
    chk("drain_count", wb_log.size(), 5);
    for (int k = 0; k < 5 && k < wb_log.size(); k++) begin
      chk("order_tag", 32'(wb_log[k][TAG_W+31:32]), 32'(10 + k));
      chk("order_data", wb_log[k][31:0], 32'(4 * k + 1));
    end
    chk("no_early_issue", n_viol, 0);
    chk("drain_in_ready", in_ready, 1);

    // 5: flush in WAIT with two ops queued
    @(negedge clk);
    s = n_start; sz = n_wbv;
    #1; drive_op(3'b100, 32'd50, 32'd5, 6'd20);
    @(negedge clk); drive_op(3'b100, 32'd60, 32'd6, 6'd21); #1;
    chk("fl_issue", div_start, 1);
    @(negedge clk); drive_op(3'b100, 32'd70, 32'd7, 6'd22);
    @(negedge clk); in_valid = 1'b0; flush = 1'b1; #1;
    chk("fl_wait_no_start", div_start, 0);
    chk("fl_in_ready_low", in_ready, 0);
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_fifo_empty", in_ready, 1);
    chk("fl_opcode_empty", div_opcode, 0);
    chk("fl_divisor_empty", div_divisor, 0);
    repeat (6) @(negedge clk);
    #1;
    chk("fl_starts", n_start - s, 1);
    chk("fl_no_wb", n_wbv - sz, 0);
    run_op("post_flush", 3'b100, 32'd81, 32'd9, 6'd23, 32'd9, `DIV_OP_DIV, 1'b0);

    // 6a: flush concurrent with wb_ready in WB, with another op queued
    wb_ready = 1'b0;
    @(negedge clk); #1; drive_op(3'b101, 32'd9, 32'd3, 6'd30);
    @(negedge clk); in_valid = 1'b0; #1;
    wait_wb(20);
    chk("wbfl_tag", wb_tag, 30);
    chk("wbfl_data", wb_data, 3);
    drive_op(3'b101, 32'd8, 32'd2, 6'd31);
    @(negedge clk); in_valid = 1'b0; #1;
    s = n_start; sz = wb_log.size();
    flush = 1'b1; wb_ready = 1'b1; #1;
    chk("wbfl_valid_held", wb_valid, 1);
    @(negedge clk); flush = 1'b0; #1;
    chk("wbfl_dropped", wb_valid, 0);
    repeat (6) @(negedge clk);
    #1;
    chk("wbfl_no_handshake", wb_log.size() - sz, 0);
    chk("wbfl_fifo_cleared", n_start - s, 0);

    // 6b: asynchronous reset while the divider is busy
    @(negedge clk); #1; drive_op(3'b100, 32'd1000, 32'd10, 6'd40);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rstw_start", div_start, 1);
    @(negedge clk); #1;
    chk("rstw_waiting", wb_valid, 0);
    rst_n = 1'b0; #1;
    chk("rstw_div_start", div_start, 0);
    chk("rstw_wb_valid", wb_valid, 0);
    chk("rstw_wb_tag", wb_tag, 0);
    chk("rstw_wb_data", wb_data, 0);
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_opcode", div_opcode, 0);
    @(negedge clk); rst_n = 1'b1;
    s = n_start; sz = n_wbv;
    repeat (6) @(negedge clk);
    #1;
    chk("rstw_no_wb", n_wbv - sz, 0);
    chk("rstw_no_start", n_start - s, 0);
    run_op("post_rst", 3'b110, 32'd29, 32'd4, 6'd41, 32'd1, `DIV_OP_DIV, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
